ctrl_seq_fsm: RTL
=================

Name: ctrl_seq_fsm

Overview:
Parametrised multi-cycle successor to the combinational opcode decoder. It sequences each instruction through fetch, decode, execute/memory and writeback states, producing one-cycle strobes for IR, PC and the register file. It holds the memory strobes until `mem_ready`, supports ALU-class opcodes beyond LOAD/STORE, and flags a sticky fault on memory timeout. Outputs drive 0 in idle states and never Z. It sits between the instruction register/memory interface and the datapath.

Parameters:
- OP_W, 4, opcode width; LOAD = all-zeros, STORE = all-ones, any other value = ALU-class op.
- ALU_W, 4, alu_op width; must be ≤ OP_W.
- ALU_PASS, 4'b0110, alu_op driven during LOAD/STORE address pass-through.
- WAIT_MAX, 15, max consecutive cycles with mem_ready low in FETCH or MEM before fault; 0 disables the timeout.

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- run  in  1  level; permits starting a new instruction.
- opcode  in  OP_W  opcode field from IR; valid in DECODE.
- mem_ready  in  1  memory handshake complete; sampled in FETCH and MEM.
- alu_op  out  ALU_W  ALU operation select.
- pc_load  out  1  PC update strobe.
- ir_load  out  1  IR capture strobe.
- mem_read  out  1  memory read request.
- mem_write  out  1  memory write request.
- reg_write  out  1  register-file write strobe.
- busy  out  1  high in every state except IDLE and FAULT.
- instr_done  out  1  one-cycle pulse on instruction retire.
- fault  out  1  sticky memory-timeout flag.

Behaviour:
- **Reset:** rst_n low asynchronously forces state = IDLE, op_q = 0 and the wait counter to 0. All outputs go to 0 immediately, including when reset arrives mid-instruction. No partial strobe completes after reset.
- **Output decode:** outputs are a Moore decode of the registered state (plus op_q). No output depends combinationally on mem_ready or run.
- **IDLE:** all outputs 0. Go to FETCH when run = 1.
- **FETCH:** mem_read = 1. Go to LATCH on the cycle mem_ready = 1 is sampled; otherwise stay.
- **LATCH:** ir_load = 1 for exactly one cycle, then DECODE.
- **DECODE:** op_q <= opcode.
  - All-zeros or all-ones opcode goes to MEM.
  - Any other opcode goes to EXEC.
- **EXEC:** alu_op = op_q[ALU_W-1:0] for one cycle, then WB.
- **MEM:** alu_op = ALU_PASS.
  - LOAD drives mem_read = 1; STORE drives mem_write = 1. The strobe is held until mem_ready is sampled high.
  - On ready: LOAD goes to WB, STORE goes to RETIRE.
  - mem_read and mem_write are never high together.
- **WB:** reg_write = 1 for one cycle, then RETIRE.
- **RETIRE:** pc_load = 1 and instr_done = 1 for one cycle.
  - Then FETCH if run = 1, else IDLE.
  - run dropping mid-instruction does not abort the instruction; it completes and retires.
- **Latency** (mem_ready high on first request cycle, measured from FETCH entry to RETIRE inclusive):
  - ALU op: 6 cycles.
  - LOAD: 6 cycles.
  - STORE: 5 cycles.
- **Timeout:**
  - The wait counter clears on entry to FETCH or MEM and increments each cycle mem_ready is sampled low in those states.
  - When the WAIT_MAX-th consecutive low sample occurs, the next state is FAULT.
  - mem_ready high on any earlier sample completes normally.
  - Counter width is clog2(WAIT_MAX+1), saturating.
  - With WAIT_MAX = 0 the FSM waits indefinitely.
- **FAULT:** fault = 1 and all strobes 0. Held until rst_n; run is ignored.
- **Default branch:** unreachable state encodings return to IDLE on the next edge with outputs 0.

Test Plan:
1. **Reset:** rst_n low mid-MEM with mem_write = 1 → all outputs 0 in the same cycle, busy = 0; after release with run = 0 the FSM stays IDLE.
2. **LOAD:** run = 1, opcode = 4'b0000, mem_ready always 1 → mem_read(FETCH), ir_load, -, mem_read + alu_op = 0110, reg_write, pc_load + instr_done; total 6 cycles.
3. **STORE:** opcode = 4'b1111 with mem_ready low 3 cycles in MEM → mem_write held 4 cycles, no reg_write, pc_load once; WAIT_MAX = 15 not hit.
4. **ALU op:** opcode = 4'b1010 → alu_op = 1010 exactly in EXEC, then reg_write, then pc_load; mem_read/mem_write 0 after FETCH.
5. **Timeout:** WAIT_MAX = 4, mem_ready held 0 in FETCH → fault = 1 after the 4th low sample, mem_read drops; fault persists with run = 1 until rst_n.
6. **Run drop:** run = 1 for back-to-back instructions, then dropped in DECODE → that instruction retires (instr_done pulse), then IDLE with busy = 0.

Source files
------------

// File: rtl/ctrl_seq_fsm_if.sv
// Sequencer <-> IR/memory/datapath bundle. master = sequencer side, slave = datapath side.
interface ctrl_seq_fsm_if #(
  parameter int OP_W  = 4,
  parameter int ALU_W = 4
);
  logic             run;
  logic [OP_W-1:0]  opcode;
  logic             mem_ready;
  logic [ALU_W-1:0] alu_op;
  logic             pc_load;
  logic             ir_load;
  logic             mem_read;
  logic             mem_write;
  logic             reg_write;
  logic             busy;
  logic             instr_done;
  logic             fault;

  modport master (
    input  run, opcode, mem_ready,
    output alu_op, pc_load, ir_load, mem_read, mem_write, reg_write, busy, instr_done, fault
  );

  modport slave (
    output run, opcode, mem_ready,
    input  alu_op, pc_load, ir_load, mem_read, mem_write, reg_write, busy, instr_done, fault
  );
endinterface

// File: rtl/ctrl_seq_fsm.sv
// Multi-cycle instruction sequencer: fetch, latch, decode, exec/mem, writeback, retire,
// with a sticky fault when memory stays unready for WAIT_MAX consecutive samples.
module ctrl_seq_fsm #(
  parameter int               OP_W     = 4,
  parameter int               ALU_W    = 4,
  parameter logic [ALU_W-1:0] ALU_PASS = ALU_W'(4'b0110),
  parameter int               WAIT_MAX = 15
) (
  input  logic           clk,
  input  logic           rst_n,
  ctrl_seq_fsm_if.master bus
);

  localparam int               CNT_W     = (WAIT_MAX > 0) ? $clog2(WAIT_MAX + 1) : 1;
  localparam bit               TO_EN     = (WAIT_MAX > 0);
  localparam logic [CNT_W-1:0] WAIT_LAST = (WAIT_MAX > 0) ? CNT_W'(WAIT_MAX - 1) : '0;
  localparam logic [OP_W-1:0]  OP_LOAD   = '0;
  localparam logic [OP_W-1:0]  OP_STORE  = '1;

  typedef enum logic [3:0] {
    S_IDLE, S_FETCH, S_LATCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_RETIRE, S_FAULT
  } state_t;

  state_t           state, state_nxt;
  logic [OP_W-1:0]  op_q;
  logic [CNT_W-1:0] wait_cnt, wait_nxt;
  logic             is_store;
  logic             timed_out;
  logic [CNT_W-1:0] wait_inc;

  logic [ALU_W-1:0] alu_op;
  logic             pc_load, ir_load, mem_read, mem_write, reg_write, busy, instr_done, fault;

  assign is_store  = (op_q == OP_STORE);
  // This low sample is the WAIT_MAX-th in a row: give up instead of counting further.
  assign timed_out = TO_EN && !bus.mem_ready && (wait_cnt == WAIT_LAST);
  assign wait_inc  = (wait_cnt == '1) ? wait_cnt : wait_cnt + 1'b1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      op_q     <= '0;
      wait_cnt <= '0;
    end else begin
      state    <= state_nxt;
      wait_cnt <= wait_nxt;
      if (state == S_DECODE) op_q <= bus.opcode;
    end
  end

  // wait_nxt defaults to 0, so the counter is clear on every entry to FETCH/MEM.
  always_comb begin
    state_nxt  = state;
    wait_nxt   = '0;
    alu_op     = '0;
    pc_load    = 1'b0;
    ir_load    = 1'b0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    reg_write  = 1'b0;
    busy       = 1'b0;
    instr_done = 1'b0;
    fault      = 1'b0;
    case (state)
      S_IDLE: begin
        if (bus.run) state_nxt = S_FETCH;
      end
      S_FETCH: begin
        busy     = 1'b1;
        mem_read = 1'b1;
        if (bus.mem_ready) state_nxt = S_LATCH;
        else if (timed_out) state_nxt = S_FAULT;
        else wait_nxt = wait_inc;
      end
      S_LATCH: begin
        busy      = 1'b1;
        ir_load   = 1'b1;
        state_nxt = S_DECODE;
      end
      S_DECODE: begin
        busy      = 1'b1;
        state_nxt = (bus.opcode == OP_LOAD || bus.opcode == OP_STORE) ? S_MEM : S_EXEC;
      end
      S_EXEC: begin
        busy      = 1'b1;
        alu_op    = op_q[ALU_W-1:0];
        state_nxt = S_WB;
      end
      S_MEM: begin
        busy      = 1'b1;
        alu_op    = ALU_PASS;
        mem_write = is_store;
        mem_read  = !is_store;
        if (bus.mem_ready) state_nxt = is_store ? S_RETIRE : S_WB;
        else if (timed_out) state_nxt = S_FAULT;
        else wait_nxt = wait_inc;
      end
      S_WB: begin
        busy      = 1'b1;
        reg_write = 1'b1;
        state_nxt = S_RETIRE;
      end
      S_RETIRE: begin
        busy       = 1'b1;
        pc_load    = 1'b1;
        instr_done = 1'b1;
        state_nxt  = bus.run ? S_FETCH : S_IDLE;
      end
      S_FAULT: begin
        fault = 1'b1;
      end
      default: begin
        state_nxt = S_IDLE;
      end
    endcase
  end

  assign bus.alu_op     = alu_op;
  assign bus.pc_load    = pc_load;
  assign bus.ir_load    = ir_load;
  assign bus.mem_read   = mem_read;
  assign bus.mem_write  = mem_write;
  assign bus.reg_write  = reg_write;
  assign bus.busy       = busy;
  assign bus.instr_done = instr_done;
  assign bus.fault      = fault;

endmodule
